// File: rtl/ultrasonic_ranger_if.sv
// Sensor pins and measurement results of the ultrasonic ranger, grouped for port use.
interface ultrasonic_ranger_if #(
    parameter int unsigned WIDTH_BITS = 32
);
    logic                  start;
    logic                  echo;
    logic                  trig;
    logic [WIDTH_BITS-1:0] echo_width;
    logic                  valid;
    logic                  timeout;
    logic                  busy;

    modport master (output start, echo, input trig, echo_width, valid, timeout, busy);
    modport slave  (input start, echo, output trig, echo_width, valid, timeout, busy);
endinterface

// File: rtl/ultrasonic_ranger.sv
// Ultrasonic ranger: trigger pulse, echo width timing with timeout, holdoff between shots.
// Define ULTRASONIC_RANGER_AUTO_TRIG_EN to free-run measurements after reset (start ignored).
module ultrasonic_ranger #(
    parameter int unsigned TRIG_CYCLES    = 120,
    parameter int unsigned TIMEOUT_CYCLES = 360000,
    parameter int unsigned HOLDOFF_CYCLES = 720000,
    parameter int unsigned WIDTH_BITS     = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    ultrasonic_ranger_if.slave bus
);
    typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF} state_t;

    // TIMEOUT_CYCLES must fit in WIDTH_BITS so the counter can never wrap.
    localparam logic [WIDTH_BITS-1:0] ONE       = WIDTH_BITS'(1);
    localparam logic [WIDTH_BITS-1:0] TRIG_LAST = WIDTH_BITS'(TRIG_CYCLES - 1);
    localparam logic [WIDTH_BITS-1:0] TMO_LIM   = WIDTH_BITS'(TIMEOUT_CYCLES);
    localparam logic [WIDTH_BITS-1:0] HOLD_LAST = WIDTH_BITS'(HOLDOFF_CYCLES - 1);

`ifdef ULTRASONIC_RANGER_AUTO_TRIG_EN
    localparam state_t HOLD_EXIT = TRIG;
    logic unused_start;
    assign unused_start = bus.start;
`else
    localparam state_t HOLD_EXIT = IDLE;
`endif

    state_t                state_q, state_d;
    logic [WIDTH_BITS-1:0] cnt_q, cnt_d;
    logic [WIDTH_BITS-1:0] width_q, width_d;
    logic                  trig_q, trig_d;
    logic                  valid_q, valid_d;
    logic                  timeout_q, timeout_d;
    logic                  echo_meta_q, echo_s_q, echo_prev_q;
    logic                  echo_rise, echo_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_meta_q <= 1'b0;
            echo_s_q    <= 1'b0;
            echo_prev_q <= 1'b0;
        end else begin
            echo_meta_q <= bus.echo;
            echo_s_q    <= echo_meta_q;
            echo_prev_q <= echo_s_q;
        end
    end

    assign echo_rise = echo_s_q & ~echo_prev_q;
    assign echo_fall = ~echo_s_q & echo_prev_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        width_d   = width_q;
        valid_d   = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
`ifdef ULTRASONIC_RANGER_AUTO_TRIG_EN
                state_d = TRIG;
                cnt_d   = '0;
`else
                if (bus.start) begin
                    state_d = TRIG;
                    cnt_d   = '0;
                end
`endif
            end
            TRIG: begin
                if (cnt_q == TRIG_LAST) begin
                    state_d = WAIT_RISE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            WAIT_RISE: begin
                // Only a real low-to-high edge starts a measurement, never a pulse already in flight.
                if (echo_rise) begin
                    state_d = MEASURE;
                    cnt_d   = ONE;
                end else if (cnt_q == TMO_LIM) begin
                    state_d   = HOLDOFF;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            MEASURE: begin
                if (echo_fall) begin
                    state_d = HOLDOFF;
                    width_d = cnt_q;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end else if (cnt_q == TMO_LIM) begin
                    state_d   = HOLDOFF;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            HOLDOFF: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = HOLD_EXIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        trig_d = (state_d == TRIG);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            width_q   <= '0;
            trig_q    <= 1'b0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            width_q   <= width_d;
            trig_q    <= trig_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.trig       = trig_q;
    assign bus.echo_width = width_q;
    assign bus.valid      = valid_q;
    assign bus.timeout    = timeout_q;
    assign bus.busy       = (state_q != IDLE);
endmodule
